// File: rtl/reg_file_param_if.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_param_if
// Brief   : Bus bundle for reg_file_param: write ports, read ports,
//           reservation request, busy flags and collision pulse.
// Revision: 1.0 - initial release
// ============================================================================
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] Rd_Addr;
  logic [ADDR_W-1:0] Rs_Addr;
  logic [ADDR_W-1:0] Rm_Addr;
  logic              Rd_Wen;
  logic              Rs_Wen;
  logic [DATA_W-1:0] Rd_Data;
  logic [DATA_W-1:0] Rs_Data;
  logic [DATA_W-1:0] Rd_Out;
  logic [DATA_W-1:0] Rs_Out;
  logic [DATA_W-1:0] Rm_Out;
  logic [ADDR_W-1:0] Rsv_Addr;
  logic              Rsv_En;
  logic              Rd_Busy;
  logic              Rs_Busy;
  logic              Rm_Busy;
  logic              Collide;

  modport master (
    output Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data,
           Rsv_Addr, Rsv_En,
    input  Rd_Out, Rs_Out, Rm_Out, Rd_Busy, Rs_Busy, Rm_Busy, Collide
  );

  modport slave (
    input  Rd_Addr, Rs_Addr, Rm_Addr, Rd_Wen, Rs_Wen, Rd_Data, Rs_Data,
           Rsv_Addr, Rsv_En,
    output Rd_Out, Rs_Out, Rm_Out, Rd_Busy, Rs_Busy, Rm_Busy, Collide
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module  : reg_file_param
// Brief   : Parameterised register file with two write ports (Rd, Rs; Rs wins
//           on same-address writes), three registered read ports, optional
//           write-through bypass, per-register busy (reservation) tracking and
//           optional hardwired-zero register 0.
// Revision: 1.0 - initial release
// ============================================================================
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input wire logic         Clock,
  input wire logic         Reset,
  reg_file_param_if.slave  bus
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit c_BYPASS = (BYPASS != 0);
  localparam bit c_ZERO   = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs     [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DATA_W-1:0] w_regs_nxt [DEPTH];
  logic [DEPTH-1:0]  w_busy_nxt;

  logic [DATA_W-1:0] r_rd_out, r_rs_out, r_rm_out;
  logic              r_rd_busy, r_rs_busy, r_rm_busy;
  logic              r_collide;

  logic [DATA_W-1:0] w_rd_val, w_rs_val, w_rm_val;
  logic              w_rd_bsy, w_rs_bsy, w_rm_bsy;
  logic              w_collide;

  // Post-edge contents of every register: Rs data overrides Rd on a shared
  // address, and a reservation overrides the busy-clear caused by a write.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_regs_nxt[i] = r_regs[i];
      w_busy_nxt[i] = r_busy[i];
      if (!(c_ZERO && (i == 0))) begin
        if (bus.Rs_Wen && (bus.Rs_Addr == ADDR_W'(i))) begin
          w_regs_nxt[i] = bus.Rs_Data;
        end else if (bus.Rd_Wen && (bus.Rd_Addr == ADDR_W'(i))) begin
          w_regs_nxt[i] = bus.Rd_Data;
        end
        if (bus.Rsv_En && (bus.Rsv_Addr == ADDR_W'(i))) begin
          w_busy_nxt[i] = 1'b1;
        end else if ((bus.Rs_Wen && (bus.Rs_Addr == ADDR_W'(i))) ||
                     (bus.Rd_Wen && (bus.Rd_Addr == ADDR_W'(i)))) begin
          w_busy_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Register array and busy vector; a hardwired-zero register 0 simply never
  // leaves its reset value because its next-state is never modified above.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= w_regs_nxt[i];
      end
      r_busy <= w_busy_nxt;
    end
  end

  // Read source: post-write view when bypassing, otherwise pre-edge contents.
  assign w_rd_val  = c_BYPASS ? w_regs_nxt[bus.Rd_Addr] : r_regs[bus.Rd_Addr];
  assign w_rs_val  = c_BYPASS ? w_regs_nxt[bus.Rs_Addr] : r_regs[bus.Rs_Addr];
  assign w_rm_val  = c_BYPASS ? w_regs_nxt[bus.Rm_Addr] : r_regs[bus.Rm_Addr];
  assign w_rd_bsy  = c_BYPASS ? w_busy_nxt[bus.Rd_Addr] : r_busy[bus.Rd_Addr];
  assign w_rs_bsy  = c_BYPASS ? w_busy_nxt[bus.Rs_Addr] : r_busy[bus.Rs_Addr];
  assign w_rm_bsy  = c_BYPASS ? w_busy_nxt[bus.Rm_Addr] : r_busy[bus.Rm_Addr];
  assign w_collide = bus.Rd_Wen && bus.Rs_Wen && (bus.Rd_Addr == bus.Rs_Addr);

  // Registered read data, busy flags and collision pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rd_out  <= '0;
      r_rs_out  <= '0;
      r_rm_out  <= '0;
      r_rd_busy <= 1'b0;
      r_rs_busy <= 1'b0;
      r_rm_busy <= 1'b0;
      r_collide <= 1'b0;
    end else begin
      r_rd_out  <= w_rd_val;
      r_rs_out  <= w_rs_val;
      r_rm_out  <= w_rm_val;
      r_rd_busy <= w_rd_bsy;
      r_rs_busy <= w_rs_bsy;
      r_rm_busy <= w_rm_bsy;
      r_collide <= w_collide;
    end
  end

  assign bus.Rd_Out  = r_rd_out;
  assign bus.Rs_Out  = r_rs_out;
  assign bus.Rm_Out  = r_rm_out;
  assign bus.Rd_Busy = r_rd_busy;
  assign bus.Rs_Busy = r_rs_busy;
  assign bus.Rm_Busy = r_rm_busy;
  assign bus.Collide = r_collide;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_file_param
// Brief   : Self-checking bench for reg_file_param. Three instances:
//           u_dut0 16/4 BYPASS=1, u_dut1 16/4 BYPASS=0,
//           u_dut2 32/5 BYPASS=1 ZERO_REG=1. Expected values are queued when
//           stimulus is applied and popped when the registered outputs appear.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

  logic clk;
  logic rst;

  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
  reg_file_param_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
  reg_file_param_if #(.DATA_W(32), .ADDR_W(5)) if2 ();

  reg_file_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) u_dut0 (
    .Clock(clk), .Reset(rst), .bus(if0.slave));
  reg_file_param #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0)) u_dut1 (
    .Clock(clk), .Reset(rst), .bus(if1.slave));
  reg_file_param #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut2 (
    .Clock(clk), .Reset(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];
  logic [31:0] e;

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same stimulus to the two 16-bit instances.
  task automatic drv(input logic rdw, input logic [3:0] rda, input logic [15:0] rdd,
                     input logic rsw, input logic [3:0] rsa, input logic [15:0] rsd,
                     input logic [3:0] rma, input logic rsve, input logic [3:0] rsva);
    if0.Rd_Wen = rdw; if0.Rd_Addr = rda; if0.Rd_Data = rdd;
    if0.Rs_Wen = rsw; if0.Rs_Addr = rsa; if0.Rs_Data = rsd;
    if0.Rm_Addr = rma; if0.Rsv_En = rsve; if0.Rsv_Addr = rsva;
    if1.Rd_Wen = rdw; if1.Rd_Addr = rda; if1.Rd_Data = rdd;
    if1.Rs_Wen = rsw; if1.Rs_Addr = rsa; if1.Rs_Data = rsd;
    if1.Rm_Addr = rma; if1.Rsv_En = rsve; if1.Rsv_Addr = rsva;
  endtask

  task automatic drv2(input logic rdw, input logic [4:0] rda, input logic [31:0] rdd,
                      input logic rsw, input logic [4:0] rsa, input logic [31:0] rsd,
                      input logic [4:0] rma, input logic rsve, input logic [4:0] rsva);
    if2.Rd_Wen = rdw; if2.Rd_Addr = rda; if2.Rd_Data = rdd;
    if2.Rs_Wen = rsw; if2.Rs_Addr = rsa; if2.Rs_Data = rsd;
    if2.Rm_Addr = rma; if2.Rsv_En = rsve; if2.Rsv_Addr = rsva;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, 4'd3, 16'h7777, 1'b0, 4'd0, 16'h0, 4'd3, 1'b1, 4'd3);
    drv2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick(); tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Out) !== e) begin errors++; $display("FAIL rst_rd_out0 got %h want %h", if0.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL rst_rm_busy0 got %h want %h", if0.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Collide) !== e) begin errors++; $display("FAIL rst_collide0 got %h want %h", if0.Collide, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL rst_rm_out1 got %h want %h", if1.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL rst_rm_out2 got %h want %h", if2.Rm_Out, e); end
    // Writes and reservation offered during reset must have been dropped.
    rst = 1'b0;
    drv(1'b0, 4'd3, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 1'b0, 4'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL rst_discard_data got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL rst_discard_busy got %h want %h", if0.Rm_Busy, e); end
  endtask

  task automatic test_bypass();
    drv(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd3, 1'b0, 4'd0);
    sb_q.push_back(32'h1234); sb_q.push_back(32'h0000);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL byp1_first got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL byp0_first got %h want %h", if1.Rm_Out, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd3, 1'b0, 4'd0);
    sb_q.push_back(32'h1234); sb_q.push_back(32'h1234);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL byp1_second got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL byp0_second got %h want %h", if1.Rm_Out, e); end
  endtask

  task automatic test_collide();
    drv(1'b1, 4'd7, 16'hAAAA, 1'b1, 4'd7, 16'h5555, 4'd7, 1'b0, 4'd0);
    sb_q.push_back(32'h5555); sb_q.push_back(32'h1);
    sb_q.push_back(32'h0000); sb_q.push_back(32'h1);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL col_data0 got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Collide) !== e) begin errors++; $display("FAIL col_pulse0 got %h want %h", if0.Collide, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL col_data1_pre got %h want %h", if1.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Collide) !== e) begin errors++; $display("FAIL col_pulse1 got %h want %h", if1.Collide, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd7, 1'b0, 4'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h5555); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Collide) !== e) begin errors++; $display("FAIL col_end0 got %h want %h", if0.Collide, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL col_data1_post got %h want %h", if1.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Collide) !== e) begin errors++; $display("FAIL col_end1 got %h want %h", if1.Collide, e); end
    // Both ports writing distinct addresses: both land, no collision.
    drv(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 4'd7, 1'b0, 4'd0);
    sb_q.push_back(32'h1111); sb_q.push_back(32'h2222); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Out) !== e) begin errors++; $display("FAIL dual_rd got %h want %h", if0.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rs_Out) !== e) begin errors++; $display("FAIL dual_rs got %h want %h", if0.Rs_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Collide) !== e) begin errors++; $display("FAIL dual_collide got %h want %h", if0.Collide, e); end
  endtask

  task automatic test_busy();
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 1'b1, 4'd5);
    sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_set0 got %h want %h", if0.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_set1_pre got %h want %h", if1.Rm_Busy, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 1'b0, 4'd0);
    sb_q.push_back(32'h1); sb_q.push_back(32'h1);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_hold0 got %h want %h", if0.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_set1_post got %h want %h", if1.Rm_Busy, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h0505, 4'd5, 1'b0, 4'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h1);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL wr_clear0 got %h want %h", if0.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Busy) !== e) begin errors++; $display("FAIL wr_clear1_pre got %h want %h", if1.Rm_Busy, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 1'b0, 4'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0505);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Busy) !== e) begin errors++; $display("FAIL wr_clear1_post got %h want %h", if1.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL wr_data1 got %h want %h", if1.Rm_Out, e); end
    // Reservation and write to the same address together: busy wins, data lands.
    drv(1'b1, 4'd5, 16'h5A5A, 1'b0, 4'd0, 16'h0, 4'd5, 1'b1, 4'd5);
    sb_q.push_back(32'h1); sb_q.push_back(32'h5A5A);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_wins0 got %h want %h", if0.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL rsv_data0 got %h want %h", if0.Rm_Out, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd5, 1'b0, 4'd0);
    sb_q.push_back(32'h1); sb_q.push_back(32'h5A5A);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Busy) !== e) begin errors++; $display("FAIL rsv_wins1 got %h want %h", if1.Rm_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL rsv_data1 got %h want %h", if1.Rm_Out, e); end
  endtask

  task automatic test_zero_reg();
    // u_dut0 has an ordinary register 0; u_dut2 has it hardwired to zero.
    drv(1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0, 4'd0, 1'b1, 4'd0);
    drv2(1'b1, 5'd0, 32'h0000FFFF, 1'b1, 5'd0, 32'h12345678, 5'd0, 1'b1, 5'd0);
    sb_q.push_back(32'hFFFF); sb_q.push_back(32'h1);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h1); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Out) !== e) begin errors++; $display("FAIL r0_normal_data got %h want %h", if0.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Busy) !== e) begin errors++; $display("FAIL r0_normal_busy got %h want %h", if0.Rd_Busy, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rd_Out !== e) begin errors++; $display("FAIL r0_zero_data got %h want %h", if2.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if2.Rd_Busy) !== e) begin errors++; $display("FAIL r0_zero_busy got %h want %h", if2.Rd_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if2.Collide) !== e) begin errors++; $display("FAIL r0_zero_collide got %h want %h", if2.Collide, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL r0_zero_rm got %h want %h", if2.Rm_Out, e); end
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 1'b0, 4'd0);
    drv2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0);
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'hFFFF);
    tick();
    e = sb_q.pop_front(); checks++; if (if2.Rd_Out !== e) begin errors++; $display("FAIL r0_zero_later got %h want %h", if2.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if2.Rd_Busy) !== e) begin errors++; $display("FAIL r0_zero_busy_later got %h want %h", if2.Rd_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Out) !== e) begin errors++; $display("FAIL r0_normal_later got %h want %h", if0.Rd_Out, e); end
  endtask

  task automatic test_wide();
    drv2(1'b0, 5'd31, 32'h0, 1'b1, 5'd31, 32'hDEADBEEF, 5'd31, 1'b0, 5'd0);
    for (int k = 0; k < 6; k++) sb_q.push_back(32'hDEADBEEF);
    tick();
    e = sb_q.pop_front(); checks++; if (if2.Rd_Out !== e) begin errors++; $display("FAIL wide_rd got %h want %h", if2.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rs_Out !== e) begin errors++; $display("FAIL wide_rs got %h want %h", if2.Rs_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL wide_rm got %h want %h", if2.Rm_Out, e); end
    drv2(1'b0, 5'd31, 32'h0, 1'b0, 5'd31, 32'h0, 5'd31, 1'b0, 5'd0);
    tick();
    e = sb_q.pop_front(); checks++; if (if2.Rd_Out !== e) begin errors++; $display("FAIL wide_rd_hold got %h want %h", if2.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rs_Out !== e) begin errors++; $display("FAIL wide_rs_hold got %h want %h", if2.Rs_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL wide_rm_hold got %h want %h", if2.Rm_Out, e); end
  endtask

  task automatic test_reset_midcycle();
    // Rs port watches register 5, still busy from the reservation test.
    drv(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd5, 16'h0, 4'd9, 1'b0, 4'd0);
    sb_q.push_back(32'hBEEF); sb_q.push_back(32'h1);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL mid_pre_data got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rs_Busy) !== e) begin errors++; $display("FAIL mid_pre_busy got %h want %h", if0.Rs_Busy, e); end
    drv(1'b0, 4'd9, 16'h0, 1'b0, 4'd5, 16'h0, 4'd9, 1'b0, 4'd0);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) sb_q.push_back(32'h0);
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL mid_rm_out got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rd_Out) !== e) begin errors++; $display("FAIL mid_rd_out got %h want %h", if0.Rd_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rs_Busy) !== e) begin errors++; $display("FAIL mid_rs_busy got %h want %h", if0.Rs_Busy, e); end
    e = sb_q.pop_front(); checks++; if (32'(if1.Rm_Out) !== e) begin errors++; $display("FAIL mid_rm_out1 got %h want %h", if1.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL mid_rm_out2 got %h want %h", if2.Rm_Out, e); end
    #2;
    rst = 1'b0;
    sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
    tick();
    e = sb_q.pop_front(); checks++; if (32'(if0.Rm_Out) !== e) begin errors++; $display("FAIL post_rst_r9 got %h want %h", if0.Rm_Out, e); end
    e = sb_q.pop_front(); checks++; if (32'(if0.Rs_Busy) !== e) begin errors++; $display("FAIL post_rst_busy5 got %h want %h", if0.Rs_Busy, e); end
    e = sb_q.pop_front(); checks++; if (if2.Rm_Out !== e) begin errors++; $display("FAIL post_rst_r31 got %h want %h", if2.Rm_Out, e); end
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 1'b0, 4'd0);
    drv2(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 1'b0, 5'd0);
    test_reset();
    test_bypass();
    test_collide();
    test_busy();
    test_zero_reg();
    test_wide();
    test_reset_midcycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter BYPASS, default 1; 1 = write-through reads, 0 = read-old-data.
REQ-004 SHALL have parameter ZERO_REG, default 0; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports Rd_Addr, Rs_Addr, Rm_Addr  input  ADDR_W  read addresses; Rd_Addr and Rs_Addr also serve as write addresses.
REQ-008 SHALL have ports Rd_Wen, Rs_Wen  input  1  write enables for ports Rd and Rs.
REQ-009 SHALL have ports Rd_Data, Rs_Data  input  DATA_W  write data.
REQ-010 SHALL have ports Rd_Out, Rs_Out, Rm_Out  output  DATA_W  registered read data.
REQ-011 SHALL have ports Rsv_Addr  input  ADDR_W and Rsv_En  input  1  register reservation request.
REQ-012 SHALL have ports Rd_Busy, Rs_Busy, Rm_Busy  output  1  registered busy flag of the addressed register.
REQ-013 SHALL have port Collide  output  1  registered pulse: both write ports targeted the same address.

Function
REQ-014 SHALL write Rd_Data to reg[Rd_Addr] when Rd_Wen=1 and Rs_Data to reg[Rs_Addr] when Rs_Wen=1, at the same rising edge.
REQ-015 SHALL, when Rd_Wen=Rs_Wen=1 and Rd_Addr=Rs_Addr, store Rs_Data (Rs wins) and assert Collide for exactly the following cycle; otherwise Collide=0.
REQ-016 SHALL register all three reads at every rising edge: one-cycle latency, outputs constant between edges.
REQ-017 SHALL, with BYPASS=1, return at each edge the post-write value (winning write data per REQ-015) for an address written at that same edge.
REQ-018 SHALL, with BYPASS=0, return the pre-edge register value regardless of same-edge writes.
REQ-019 SHALL maintain a DEPTH-bit busy vector: Rsv_En=1 sets busy[Rsv_Addr]; any write to an address clears its busy bit.
REQ-020 SHALL, when a reservation and a write target the same address at one edge, leave busy set (reservation wins) and still perform the write.
REQ-021 SHALL register *_Busy alongside *_Out with the same BYPASS rule: BYPASS=1 shows post-edge busy, BYPASS=0 shows pre-edge busy.
REQ-022 SHALL, with ZERO_REG=1, ignore writes and reservations to address 0, read 0 from it, and report it never busy; Collide still asserts per REQ-015 for address 0.
REQ-023 SHALL treat any read port addressing any register independently; multiple ports may read the same address at once.

Reset
REQ-024 SHALL, while Reset=1, immediately clear all DEPTH registers, the busy vector, all *_Out, all *_Busy and Collide to 0, independent of Clock.
REQ-025 SHALL discard writes and reservations presented at an edge where Reset=1; normal operation resumes at the first rising edge after Reset deasserts.
REQ-026 SHALL have no outputs undefined after reset; all registers read as 0 until written.

Verification
REQ-027 SHALL verify: reset, then Rd_Wen=1 Rd_Addr=3 Rd_Data=0x1234, Rm_Addr=3 same edge -> BYPASS=1: Rm_Out=0x1234 next cycle; BYPASS=0: Rm_Out=0x0000, then 0x1234 one cycle later.
REQ-028 SHALL verify: Rd_Wen=Rs_Wen=1, both Addr=7, Rd_Data=0xAAAA, Rs_Data=0x5555 -> reg7=0x5555, Collide=1 for one cycle then 0.
REQ-029 SHALL verify: Rsv_En=1 Rsv_Addr=5 -> Rm_Busy=1 with Rm_Addr=5; later Rs_Wen=1 Rs_Addr=5 -> Rm_Busy=0; simultaneous Rsv_En and write to 5 -> busy stays 1, data updated.
REQ-030 SHALL verify: ZERO_REG=1, write 0xFFFF and reserve address 0 -> Rd_Out=0x0000, Rd_Busy=0.
REQ-031 SHALL verify: write 0xBEEF to reg 9, assert Reset mid-cycle (between edges) -> all outputs 0 immediately; after release reading 9 returns 0x0000.
REQ-032 SHALL verify with DATA_W=32, ADDR_W=5: write 0xDEADBEEF to reg 31 and read on all three ports -> all return 0xDEADBEEF.
